// File: rtl/ksa16_stream_stage_pkg.sv
// Shared definitions for the KSA16 streaming stage: operand/result widths,
// the FIFO result-entry layout and the Kogge-Stone prefix adder function.
package ksa16_stream_stage_pkg;

  localparam int KSA_W     = 16;
  localparam int KSA_RES_W = KSA_W + 1;
  localparam int KSA_LVLS  = $clog2(KSA_W);

  // One FIFO entry: carry-out above the sum, matching the {cout,sum} view.
  typedef struct packed {
    logic             cout;
    logic [KSA_W-1:0] sum;
  } ksa_res_t;

  // Kogge-Stone parallel-prefix add with carry-in tied to zero.
  // Level lv combines each (g,p) pair with the pair 2^lv bits below it.
  function automatic ksa_res_t ksa16_add(input logic [KSA_W-1:0] a,
                                         input logic [KSA_W-1:0] b);
    logic [KSA_W-1:0] x;
    logic [KSA_W-1:0] g;
    logic [KSA_W-1:0] p;
    logic [KSA_W-1:0] g_n;
    logic [KSA_W-1:0] p_n;
    ksa_res_t         res;
    x = a ^ b;
    g = a & b;
    p = x;
    for (int lv = 0; lv < KSA_LVLS; lv++) begin
      g_n = g;
      p_n = p;
      for (int i = 0; i < KSA_W; i++) begin
        if (i >= (1 << lv)) begin
          g_n[i] = g[i] | (p[i] & g[i - (1 << lv)]);
          p_n[i] = p[i] & p[i - (1 << lv)];
        end else begin
          g_n[i] = g[i];
          p_n[i] = p[i];
        end
      end
      g = g_n;
      p = p_n;
    end
    // g[i] is now the carry out of bit i; bit i sums with the carry from i-1.
    res.cout = g[KSA_W-1];
    res.sum  = x ^ {g[KSA_W-2:0], 1'b0};
    return res;
  endfunction

endpackage

// File: rtl/ksa16_stream_stage_fifo.sv
// Synchronous result FIFO with a registered head entry. The head register
// keeps the last popped value while the FIFO is empty.
module ksa_result_fifo
  import ksa16_stream_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  ksa_res_t push_data,
  input  logic     pop,
  output logic     full,
  output logic     empty,
  output ksa_res_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [AW:0] rd_ptr_nxt_s;
  logic [AW:0] occ_s;
  logic [AW:0] rem_s;
  logic        push_ok_s;
  logic        pop_ok_s;
  ksa_res_t    mem_r [DEPTH];
  ksa_res_t    head_r;
  ksa_res_t    head_nxt_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign occ_s     = wr_ptr_r - rd_ptr_r;
  assign head      = head_r;

  // Next read pointer and the number of entries left once the pop is applied.
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    rem_s        = occ_s;
    if (pop_ok_s) begin
      rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, 1'b1};
      rem_s        = occ_s - {{AW{1'b0}}, 1'b1};
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
      rem_s        = occ_s;
    end
  end

  // Pick the head value visible after this edge: a stored entry, the entry
  // being pushed into an otherwise empty FIFO, or the held last value.
  always_comb begin
    head_nxt_s = head_r;
    if (rem_s != {(AW+1){1'b0}}) begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end else if (push_ok_s) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = head_r;
    end
  end

  // Pointer and head register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      head_r   <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      rd_ptr_r <= rd_ptr_nxt_s;
      head_r   <= head_nxt_s;
    end
  end

  // Entry storage; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ksa16_stream_stage_ksa.sv
// Combinational 16-bit Kogge-Stone adder (cin = 0) producing a {cout,sum} entry.
module ksa16
  import ksa16_stream_stage_pkg::*;
(
  input  logic [KSA_W-1:0] a,
  input  logic [KSA_W-1:0] b,
  output ksa_res_t         res
);

  assign res = ksa16_add(a, b);

endmodule

// File: rtl/ksa16_stream_stage.sv
// Streaming wrapper around KSA16: operand register on a valid/ready input,
// result FIFO on a valid/ready output, and bring-up result/carry counters.
module ksa16_stream_stage
  import ksa16_stream_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
`ifdef USE_POWER_PINS
  inout  wire               vdd,
  inout  wire               vss,
`endif
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [KSA_W-1:0]  in_a,
  input  logic [KSA_W-1:0]  in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KSA_W-1:0]  out_sum,
  output logic              out_cout,
  output logic [CNT_W-1:0]  result_cnt,
  output logic [CNT_W-1:0]  carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             op_valid_r;
  logic [KSA_W-1:0] op_a_r;
  logic [KSA_W-1:0] op_b_r;
  logic [CNT_W-1:0] result_cnt_r;
  logic [CNT_W-1:0] carry_cnt_r;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             pop_s;
  logic             fifo_can_push_s;
  logic             move_s;
  logic             accept_s;
  ksa_res_t         add_res_s;
  ksa_res_t         head_s;

  assign out_valid       = ~fifo_empty_s;
  assign pop_s           = out_valid & out_ready;
  // A full FIFO still takes a result when its head leaves on the same edge.
  assign fifo_can_push_s = ~fifo_full_s | pop_s;
  assign move_s          = op_valid_r & fifo_can_push_s;
  assign in_ready        = ~op_valid_r | fifo_can_push_s;
  assign accept_s        = in_valid & in_ready;
  assign out_sum         = head_s.sum;
  assign out_cout        = head_s.cout;
  assign result_cnt      = result_cnt_r;
  assign carry_cnt       = carry_cnt_r;

  // Adder sees only the registered operands, never the live inputs.
  ksa16 u_ksa16 (
    .a   (op_a_r),
    .b   (op_b_r),
    .res (add_res_s)
  );

  ksa_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (move_s),
    .push_data (add_res_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (head_s)
  );

  // Operand register: refills on the same edge its contents move to the FIFO.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      op_valid_r <= 1'b0;
      op_a_r     <= {KSA_W{1'b0}};
      op_b_r     <= {KSA_W{1'b0}};
    end else if (accept_s) begin
      op_valid_r <= 1'b1;
      op_a_r     <= in_a;
      op_b_r     <= in_b;
    end else if (move_s) begin
      op_valid_r <= 1'b0;
    end
  end

  // Delivered-result and carry-out counters, advanced on each pop, wrapping.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      result_cnt_r <= {CNT_W{1'b0}};
      carry_cnt_r  <= {CNT_W{1'b0}};
    end else if (pop_s) begin
      result_cnt_r <= result_cnt_r + CNT_ONE;
      if (head_s.cout) carry_cnt_r <= carry_cnt_r + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_ksa16_stream_stage.sv
// Directed testbench for ksa16_stream_stage: reset, latency, carry cases,
// back-pressure fill, full-rate streaming, mid-run reset and counter wrap.
module tb_ksa16_stream_stage;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        in_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid, out_cout;
  logic [15:0] out_sum, result_cnt, carry_cnt;

  logic        in_valid4, out_ready4;
  logic [15:0] in_a4, in_b4;
  logic        in_ready4, out_valid4, out_cout4;
  logic [15:0] out_sum4;
  logic [3:0]  result_cnt4, carry_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ksa16_stream_stage #(.DEPTH(4), .CNT_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .result_cnt(result_cnt), .carry_cnt(carry_cnt)
  );

  ksa16_stream_stage #(.DEPTH(4), .CNT_W(4)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(wb_rst_i),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_a(in_a4), .in_b(in_b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_sum(out_sum4),
    .out_cout(out_cout4), .result_cnt(result_cnt4), .carry_cnt(carry_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 16'h0; in_b = 16'h0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; in_a4 = 16'h0; in_b4 = 16'h0;
    tick(); tick();
    wb_rst_i = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_sum !== 16'h0000) begin n_fail++; $display("FAIL reset_out_sum got %h want 0000", out_sum); end
    n_checks++; if (out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got %b want 0", out_cout); end
    n_checks++; if (result_cnt !== 16'd0 || carry_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_counters got %0d/%0d want 0/0", result_cnt, carry_cnt); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h4321;
    tick();                       // accept edge
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_no_bypass got out_valid=%b want 0", out_valid); end
    tick();                       // operand moves into FIFO
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got out_valid=%b want 1", out_valid); end
    n_checks++; if (out_sum !== 16'h5555 || out_cout !== 1'b0) begin n_fail++; $display("FAIL basic_sum got %b_%h want 0_5555", out_cout, out_sum); end
    tick();                       // popped
    n_checks++; if (result_cnt !== 16'd1 || carry_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_counters got %0d/%0d want 1/0", result_cnt, carry_cnt); end
    n_checks++; if (out_valid !== 1'b0 || out_sum !== 16'h5555) begin n_fail++; $display("FAIL basic_hold got v=%b sum=%h want v=0 sum=5555", out_valid, out_sum); end
  endtask

  task automatic test_carry();
    logic [15:0] va [2];
    logic [15:0] vb [2];
    va[0] = 16'hFFFF; vb[0] = 16'h0001;
    va[1] = 16'h8000; vb[1] = 16'h8000;
    out_ready = 1'b1;
    for (int v = 0; v < 2; v++) begin
      in_valid = 1'b1; in_a = va[v]; in_b = vb[v];
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4 && !out_valid; k++) tick();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL carry_timeout vec %0d got out_valid=%b want 1", v, out_valid); end
      n_checks++; if (out_sum !== 16'h0000 || out_cout !== 1'b1) begin n_fail++; $display("FAIL carry_sum vec %0d got %b_%h want 1_0000", v, out_cout, out_sum); end
      tick();
      n_checks++; if (carry_cnt !== 16'(v + 1) || result_cnt !== 16'(v + 2)) begin n_fail++; $display("FAIL carry_counters vec %0d got %0d/%0d want %0d/%0d", v, result_cnt, carry_cnt, v + 2, v + 1); end
    end
  endtask

  task automatic test_full();
    int idx = 0;
    int got = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = 16'(idx); in_b = 16'(idx);
      #1;
      if (in_ready) idx++;
      tick();
    end
    n_checks++; if (idx != 5) begin n_fail++; $display("FAIL full_accepts got %0d want 5", idx); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'h0000) begin n_fail++; $display("FAIL full_head_stable got v=%b sum=%h want v=1 sum=0000", out_valid, out_sum); end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && got < 5; c++) begin
      if (out_valid) begin
        n_checks++; if (out_sum !== 16'(2 * got)) begin n_fail++; $display("FAIL full_order pop %0d got %h want %h", got, out_sum, 16'(2 * got)); end
        got++;
      end
      tick();
    end
    n_checks++; if (got != 5 || out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain got %0d results v=%b want 5 v=0", got, out_valid); end
    n_checks++; if (result_cnt !== 16'd8) begin n_fail++; $display("FAIL full_result_cnt got %0d want 8", result_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [16:0] q[$];
    int idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = 16'h0100 + 16'(idx); in_b = 16'(idx);
      #1;
      if (in_ready) begin q.push_back({1'b0, in_a} + {1'b0, in_b}); idx++; end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1'b1; in_a = 16'h0100 + 16'(idx); in_b = 16'(idx);
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cycle %0d got %b want 1", c, in_ready); end
      n_checks++; if (out_valid !== 1'b1 || {out_cout, out_sum} !== q[0]) begin n_fail++; $display("FAIL b2b_pop cycle %0d got v=%b %h want v=1 %h", c, out_valid, {out_cout, out_sum}, q[0]); end
      void'(q.pop_front());
      q.push_back({1'b0, in_a} + {1'b0, in_b});
      idx++;
      tick();
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      if (out_valid) begin
        n_checks++; if ({out_cout, out_sum} !== q[0]) begin n_fail++; $display("FAIL b2b_drain got %h want %h", {out_cout, out_sum}, q[0]); end
        void'(q.pop_front());
      end
      tick();
    end
    n_checks++; if (q.size() != 0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_loss got %0d missing v=%b want 0 missing v=0", q.size(), out_valid); end
  endtask

  task automatic test_reset_mid();
    bit extra = 1'b0;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 16'hAAA0 + 16'(k); in_b = 16'h0100;
      tick();
    end
    in_valid = 1'b0;
    tick();
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    n_checks++; if (result_cnt !== 16'd0 || carry_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_counters got %0d/%0d want 0/0", result_cnt, carry_cnt); end
    out_ready = 1'b1; in_valid = 1'b1; in_a = 16'h0001; in_b = 16'h0002;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4 && !out_valid; k++) tick();
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 16'h0003 || out_cout !== 1'b0) begin n_fail++; $display("FAIL midrst_sum got v=%b %b_%h want v=1 0_0003", out_valid, out_cout, out_sum); end
    tick();
    for (int k = 0; k < 4; k++) begin
      if (out_valid) extra = 1'b1;
      tick();
    end
    n_checks++; if (extra || result_cnt !== 16'd1) begin n_fail++; $display("FAIL midrst_single got extra=%b cnt=%0d want extra=0 cnt=1", extra, result_cnt); end
  endtask

  task automatic test_wrap();
    int  pops = 0;
    bit  seen15 = 1'b0;
    in_valid4 = 1'b1; in_a4 = 16'hFFFF; in_b4 = 16'h0001; out_ready4 = 1'b1;
    for (int c = 0; c < 40 && pops < 16; c++) begin
      if (out_valid4) pops++;
      tick();
      if (pops == 15 && !seen15) begin
        seen15 = 1'b1;
        n_checks++; if (result_cnt4 !== 4'd15 || carry_cnt4 !== 4'd15) begin n_fail++; $display("FAIL wrap_pre got %0d/%0d want 15/15", result_cnt4, carry_cnt4); end
      end
    end
    in_valid4 = 1'b0;
    n_checks++; if (pops != 16 || result_cnt4 !== 4'd0 || carry_cnt4 !== 4'd0) begin n_fail++; $display("FAIL wrap_zero got pops=%0d cnt=%0d/%0d want 16 0/0", pops, result_cnt4, carry_cnt4); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_full();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
